// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg -- shared definitions for the RAM arbiter slice.
//   state_t   : arbiter FSM states (IDLE, ACCESS, DONE)
//   ADDRWIDTH : default RAM address width
//   idx_width : width of a requester index for a given requester count
package ram_arb_pkg;

  localparam int ADDRWIDTH = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // At least one bit, even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- requester and RAM-side bus of the RAM arbiter.
//   Requester side : i_req, i_we, i_addr, i_wdata (packed per requester),
//                    o_gnt, o_rvalid (one-hot pulses), o_rdata
//   RAM side       : o_addr, o_D, i_D, WE, RE
//   Status         : o_busy
// Modports: master = requesters + RAM model, slave = arbiter.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int NREQ  = 11,
  parameter int ADDRW = ADDRWIDTH
);

  logic [NREQ-1:0]       i_req;
  logic [NREQ-1:0]       i_we;
  logic [NREQ*ADDRW-1:0] i_addr;
  logic [NREQ*8-1:0]     i_wdata;
  logic [NREQ-1:0]       o_gnt;
  logic [NREQ-1:0]       o_rvalid;
  logic [7:0]            o_rdata;
  logic [ADDRW-1:0]      o_addr;
  logic [7:0]            o_D;
  logic [7:0]            i_D;
  logic                  WE;
  logic                  RE;
  logic                  o_busy;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_D,
    input  o_gnt, o_rvalid, o_rdata, o_addr, o_D, WE, RE, o_busy
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_D,
    output o_gnt, o_rvalid, o_rdata, o_addr, o_D, WE, RE, o_busy
  );

endinterface

// File: rtl/rr_picker.sv
// rr_picker -- combinational round-robin selector.
//   req   : request vector
//   last  : index of the previous winner
//   found : any request bit set
//   idx   : first set bit searching upward from last+1, wrapping
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 11,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the search so no path
    // leaves a value unassigned, which would infer a latch.
    found = 1'b0;
    idx   = last;
    k     = 0;
    // Scan from the farthest candidate (last itself) down to the nearest
    // (last+1); the last hit written is therefore the highest priority.
    for (int i = NREQ; i >= 1; i--) begin
      k = int'(last) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[k]) begin
        found = 1'b1;
        idx   = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter -- round-robin arbiter granting NREQ requesters single-byte
// access to one RAM with a fixed access latency.
//   i_clk : clock
//   i_rst : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave (requests, grants, read data, RAM pins)
// Parameters: NREQ requesters, ADDRW address bits, RAM_LAT (1..15) cycles
// WE/RE are held per access.
// Optional build: define RAM_ARB_WPRIO_EN to give pending writes priority
// over reads (still round-robin inside each class).
//
// Per access: IDLE (pick) -> ACCESS x RAM_LAT -> DONE (read-valid) -> IDLE.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ    = 11,
  parameter int ADDRW   = ADDRWIDTH,
  parameter int RAM_LAT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ram_arbiter_if.slave bus
);

  localparam int IDXW = idx_width(NREQ);
  localparam int CNTW = 4;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  last_q;     // current/previous winner
  logic             acc_we_q;
  logic [CNTW-1:0]  cnt_q;      // cycles spent in ACCESS
  logic [ADDRW-1:0] addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;

  logic             sel_found;
  logic [IDXW-1:0]  sel_idx;

`ifdef RAM_ARB_WPRIO_EN
  logic            wr_found, any_found;
  logic [IDXW-1:0] wr_idx, any_idx;

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_pick_wr (
    .req   (bus.i_req & bus.i_we),
    .last  (last_q),
    .found (wr_found),
    .idx   (wr_idx)
  );

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_pick_any (
    .req   (bus.i_req),
    .last  (last_q),
    .found (any_found),
    .idx   (any_idx)
  );

  assign sel_found = any_found;
  assign sel_idx   = wr_found ? wr_idx : any_idx;
`else
  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req   (bus.i_req),
    .last  (last_q),
    .found (sel_found),
    .idx   (sel_idx)
  );
`endif

  // Next state and outputs. WE/RE are decoded from the state register rather
  // than registered themselves, so asserting reset drops them at once.
  always_comb begin
    state_d      = state_q;
    bus.o_gnt    = '0;
    bus.o_rvalid = '0;
    bus.WE       = 1'b0;
    bus.RE       = 1'b0;
    bus.o_busy   = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (sel_found) state_d = ACCESS;
      end
      ACCESS: begin
        bus.WE = acc_we_q;
        bus.RE = ~acc_we_q;
        if (cnt_q == '0) bus.o_gnt = NREQ'(1) << last_q;
        if (cnt_q == CNTW'(RAM_LAT - 1)) state_d = DONE;
      end
      DONE: begin
        if (!acc_we_q) bus.o_rvalid = NREQ'(1) << last_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      last_q   <= IDXW'(NREQ - 1);   // index 0 wins first after reset
      acc_we_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (sel_found) begin
            last_q   <= sel_idx;
            acc_we_q <= bus.i_we[sel_idx];
            addr_q   <= bus.i_addr[int'(sel_idx)*ADDRW +: ADDRW];
            wdata_q  <= bus.i_wdata[int'(sel_idx)*8 +: 8];
            cnt_q    <= '0;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(RAM_LAT - 1) && !acc_we_q) rdata_q <= bus.i_D;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_addr  = addr_q;
  assign bus.o_D     = wdata_q;
  assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter -- self-checking bench for ram_arbiter.
// Directed table of per-cycle vectors, hand-written multi-cycle sequences
// (idle after reset, round-robin order, reset mid-access, write priority),
// then randomized traffic against a transaction-level reference model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int NREQ  = 11;
  localparam int ADDRW = ADDRWIDTH;
  localparam int L     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.NREQ(NREQ), .ADDRW(ADDRW)) bus ();

  ram_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .RAM_LAT(L)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int               m_cyc, m_t0, m_w, m_last;
  bit               m_act, m_we;
  logic [ADDRW-1:0] m_addr;
  logic [7:0]       m_d, m_rdata;

  task automatic model_reset();
    m_cyc   = 0;
    m_act   = 1'b0;
    m_last  = NREQ - 1;
    m_rdata = 8'h00;
  endtask

  // First set bit of v in the order last+1, last+2, ... (mod NREQ); -1 if none.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    int order[$];
    for (int i = 0; i < NREQ; i++) order.push_back((last + 1 + i) % NREQ);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  // Called at the negedge of every consecutive cycle while the model runs.
  task automatic model_step();
    logic [NREQ-1:0] e_gnt, e_rv;
    bit in_acc, busy;
    int w;
    e_gnt  = '0;
    e_rv   = '0;
    in_acc = m_act && (m_cyc >= m_t0 + 1) && (m_cyc <= m_t0 + L);
    busy   = m_act && (m_cyc <= m_t0 + L + 1);
    if (m_act && m_cyc == m_t0 + 1) e_gnt[m_w] = 1'b1;
    if (m_act && m_cyc == m_t0 + L + 1 && !m_we) e_rv[m_w] = 1'b1;
    check("m_gnt",    64'(bus.o_gnt),    64'(e_gnt));
    check("m_rvalid", 64'(bus.o_rvalid), 64'(e_rv));
    check("m_busy",   64'(bus.o_busy),   64'(busy));
    check("m_we",     64'(bus.WE),       64'(in_acc && m_we));
    check("m_re",     64'(bus.RE),       64'(in_acc && !m_we));
    check("m_rdata",  64'(bus.o_rdata),  64'(m_rdata));
    if (in_acc) begin
      check("m_addr", 64'(bus.o_addr), 64'(m_addr));
      if (m_we) check("m_wdata", 64'(bus.o_D), 64'(m_d));
    end
    if (m_act && m_cyc == m_t0 + L && !m_we) m_rdata = bus.i_D;
    if (!busy) begin
      m_act = 1'b0;
`ifdef RAM_ARB_WPRIO_EN
      w = rr_pick(bus.i_req & bus.i_we, m_last);
      if (w < 0) w = rr_pick(bus.i_req, m_last);
`else
      w = rr_pick(bus.i_req, m_last);
`endif
      if (w >= 0) begin
        m_act  = 1'b1;
        m_t0   = m_cyc;
        m_w    = w;
        m_we   = bus.i_we[w];
        m_addr = bus.i_addr[w*ADDRW +: ADDRW];
        m_d    = bus.i_wdata[w*8 +: 8];
        m_last = w;
      end
    end
    m_cyc++;
  endtask

  // ---------------- helpers ----------------
  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Leaves the bench at posedge+1 of the first idle cycle after release.
  task automatic do_reset();
    rst_n       = 1'b0;
    bus.i_req   = '0;
    bus.i_we    = '0;
    @(negedge clk);
    check("rst_busy",   64'(bus.o_busy),   64'(0));
    check("rst_gnt",    64'(bus.o_gnt),    64'(0));
    check("rst_rvalid", 64'(bus.o_rvalid), 64'(0));
    check("rst_rdata",  64'(bus.o_rdata),  64'(0));
    check("rst_addr",   64'(bus.o_addr),   64'(0));
    check("rst_D",      64'(bus.o_D),      64'(0));
    check("rst_we_re",  64'({bus.WE, bus.RE}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  we;
    logic [7:0]       d_in;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  rv;
    logic             wr;
    logic             rd;
    logic             busy;
    logic [ADDRW-1:0] addr;
    logic [7:0]       dout;
    logic [7:0]       rdata;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int gi[$], gc[$];
    int c;
    logic [NREQ-1:0] exp_order[2];

    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gi[$];
    int gc[$];
    int c;
    int exp_first, exp_second;

    bus.i_req   = '0;
    bus.i_we    = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    bus.i_D     = '0;

    //         req      we       d_in   gnt      rv       wr    rd    busy  addr         dout   rdata
    tbl[0] = '{11'h008, 11'h000, 8'h00, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 23'h000000, 8'h00, 8'h00};
    tbl[1] = '{11'h000, 11'h000, 8'h00, 11'h008, 11'h000, 1'b0, 1'b1, 1'b1, 23'h000400, 8'h00, 8'h00};
    tbl[2] = '{11'h040, 11'h000, 8'hA5, 11'h000, 11'h000, 1'b0, 1'b1, 1'b1, 23'h000400, 8'h00, 8'h00};
    tbl[3] = '{11'h000, 11'h000, 8'h3C, 11'h000, 11'h008, 1'b0, 1'b0, 1'b1, 23'h000000, 8'h00, 8'hA5};
    tbl[4] = '{11'h001, 11'h001, 8'h00, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 23'h000000, 8'h00, 8'hA5};
    tbl[5] = '{11'h000, 11'h000, 8'h00, 11'h001, 11'h000, 1'b1, 1'b0, 1'b1, 23'h002000, 8'h5A, 8'hA5};
    tbl[6] = '{11'h000, 11'h000, 8'hFF, 11'h000, 11'h000, 1'b1, 1'b0, 1'b1, 23'h002000, 8'h5A, 8'hA5};
    tbl[7] = '{11'h000, 11'h000, 8'h00, 11'h000, 11'h000, 1'b0, 1'b0, 1'b1, 23'h000000, 8'h00, 8'hA5};
    tbl[8] = '{11'h000, 11'h000, 8'h00, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 23'h000000, 8'h00, 8'hA5};

    // Idle after reset release.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy",  64'(bus.o_busy), 64'(0));
      check("idle_we_re", 64'({bus.WE, bus.RE}), 64'(0));
    end
    @(posedge clk); #1;

    // Directed read by 3, write by 0; request 6 raised and dropped mid-access.
    do_reset();
    bus.i_addr[3*ADDRW +: ADDRW] = 23'h000400;
    bus.i_addr[6*ADDRW +: ADDRW] = 23'h000666;
    bus.i_addr[0*ADDRW +: ADDRW] = 23'h002000;
    bus.i_wdata[0*8 +: 8]        = 8'h5A;
    for (int r = 0; r < 9; r++) begin
      bus.i_req = tbl[r].req;
      bus.i_we  = tbl[r].we;
      bus.i_D   = tbl[r].d_in;
      @(negedge clk);
      check($sformatf("tbl%0d_gnt", r),    64'(bus.o_gnt),    64'(tbl[r].gnt));
      check($sformatf("tbl%0d_rvalid", r), 64'(bus.o_rvalid), 64'(tbl[r].rv));
      check($sformatf("tbl%0d_WE", r),     64'(bus.WE),       64'(tbl[r].wr));
      check($sformatf("tbl%0d_RE", r),     64'(bus.RE),       64'(tbl[r].rd));
      check($sformatf("tbl%0d_busy", r),   64'(bus.o_busy),   64'(tbl[r].busy));
      check($sformatf("tbl%0d_rdata", r),  64'(bus.o_rdata),  64'(tbl[r].rdata));
      if (tbl[r].wr || tbl[r].rd)
        check($sformatf("tbl%0d_addr", r), 64'(bus.o_addr), 64'(tbl[r].addr));
      if (tbl[r].wr)
        check($sformatf("tbl%0d_D", r), 64'(bus.o_D), 64'(tbl[r].dout));
      @(posedge clk); #1;
    end

    // All requesters reading continuously: order 0..10,0, spacing L+2.
    do_reset();
    bus.i_req = '1;
    bus.i_we  = '0;
    c = 0;
    while (gi.size() < NREQ + 1 && c < 200) begin
      @(negedge clk);
      if (bus.o_gnt != '0) begin
        check("rr_onehot", 64'($countones(bus.o_gnt)), 64'(1));
        gi.push_back(idx_of(bus.o_gnt));
        gc.push_back(c);
      end
      c++;
    end
    check("rr_grant_count", 64'(gi.size()), 64'(NREQ + 1));
    foreach (gi[i]) begin
      check($sformatf("rr_order%0d", i), 64'(gi[i]), 64'(i % NREQ));
      if (i > 0) check($sformatf("rr_space%0d", i), 64'(gc[i] - gc[i-1]), 64'(L + 2));
    end

    // Reset pulsed in the first ACCESS cycle of a read.
    do_reset();
    bus.i_req = NREQ'(1) << 5;
    bus.i_we  = '0;
    @(posedge clk); #2;
    check("abort_gnt", 64'(bus.o_gnt), 64'(NREQ'(1) << 5));
    check("abort_re_before", 64'(bus.RE), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_re_after", 64'(bus.RE), 64'(0));
    check("abort_we_after", 64'(bus.WE), 64'(0));
    check("abort_busy", 64'(bus.o_busy), 64'(0));
    @(posedge clk); #1;
    bus.i_req = (NREQ'(1) << 0) | (NREQ'(1) << 5) | (NREQ'(1) << 9);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_rvalid5_%0d", i), 64'(bus.o_rvalid[5]), 64'(0));
      if (i == 1) check("abort_next_gnt", 64'(bus.o_gnt), 64'(1));
    end
    @(posedge clk); #1;

    // Mixed read (2) / write (7) from idle; each winner drops after its grant.
    do_reset();
    bus.i_req = (NREQ'(1) << 2) | (NREQ'(1) << 7);
    bus.i_we  = NREQ'(1) << 7;
`ifdef RAM_ARB_WPRIO_EN
    exp_first  = 7;
    exp_second = 2;
`else
    exp_first  = 2;
    exp_second = 7;
`endif
    gi.delete();
    c = 0;
    while (gi.size() < 2 && c < 50) begin
      @(negedge clk);
      if (bus.o_gnt != '0) begin
        gi.push_back(idx_of(bus.o_gnt));
        bus.i_req = bus.i_req & ~bus.o_gnt;
      end
      c++;
    end
    check("mix_grant_count", 64'(gi.size()), 64'(2));
    if (gi.size() == 2) begin
      check("mix_first",  64'(gi[0]), 64'(exp_first));
      check("mix_second", 64'(gi[1]), 64'(exp_second));
    end
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(3) == 0) bus.i_req = NREQ'($urandom & $urandom);
      if ($urandom_range(15) == 0) bus.i_req = '1;
      bus.i_we = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        bus.i_addr[k*ADDRW +: ADDRW] = ADDRW'($urandom);
        bus.i_wdata[k*8 +: 8]        = 8'($urandom);
      end
      bus.i_D = 8'($urandom);
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
